// File: rtl/conv_mac_unit.sv
// Sequential convolution MAC: one output pixel = bias + sum over D*F*F signed products.
// A single multiplier handles one element per cycle; valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for a job, i_ready high
// RUN   | one multiply-accumulate per cycle over the latched window/filter
// DONE  | result held on o_result with o_valid high until o_ready
module conv_mac_unit #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32,
  parameter int F     = 3,
  parameter int D     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [D*F*F*IN_W-1:0]   i_window,
  input  logic [D*F*F*IN_W-1:0]   i_filter,
  input  logic [OUT_W-1:0]        i_bias,
  input  logic                    i_relu_en,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [OUT_W-1:0]        o_result
);

  localparam int N     = D * F * F;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [OUT_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] result_q, result_d;
  logic [N*IN_W-1:0]       win_q, win_d;
  logic [N*IN_W-1:0]       filt_q, filt_d;
  logic                    relu_q, relu_d;

  logic signed [IN_W-1:0]   win_el, filt_el;
  logic signed [2*IN_W-1:0] prod;
  logic signed [OUT_W-1:0]  prod_ext, sum;

  // Explicit element mux keeps the select in range for every legal N, including N=1.
  always_comb begin
    win_el  = '0;
    filt_el = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        win_el  = win_q[IN_W*k +: IN_W];
        filt_el = filt_q[IN_W*k +: IN_W];
      end
    end
  end

  assign prod     = win_el * filt_el;
  assign prod_ext = OUT_W'(prod);
  assign sum      = acc_q + prod_ext;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    win_d    = win_q;
    filt_d   = filt_q;
    relu_d   = relu_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          win_d   = i_window;
          filt_d  = i_filter;
          relu_d  = i_relu_en;
          acc_d   = i_bias;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          result_d = (relu_q && sum[OUT_W-1]) ? '0 : sum;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      win_q    <= '0;
      filt_q   <= '0;
      relu_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      win_q    <= win_d;
      filt_q   <= filt_d;
      relu_q   <= relu_d;
    end
  end

  assign i_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_result = result_q;

endmodule
